sync_fifo_flags: RTL and testbench



---
 rtl/fifo_pkg.sv | 29 ++
 rtl/fifo_mem.sv | 37 +++
 rtl/sync_fifo_flags.sv | 123 ++++++++++++
 tb/tb_sync_fifo_flags.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the single-clock flag FIFO.
// Pointer compare helper and threshold range limits.
package fifo_pkg;

  localparam int unsigned PTR_MAX_W = 32;
  localparam int unsigned AFULL_MIN = 1;
  localparam int unsigned AEMPTY_MIN = 0;

  // Full when the address bits match and the wrap bits differ.
  function automatic logic ptrs_full(
    input logic [PTR_MAX_W-1:0] wp,
    input logic [PTR_MAX_W-1:0] rp,
    input logic [4:0]           asize
  );
    logic [PTR_MAX_W-1:0] diff;
    logic [PTR_MAX_W-1:0] amask;
    diff  = wp ^ rp;
    amask = (PTR_MAX_W'(1) << asize) - PTR_MAX_W'(1);
    return diff[asize] && ((diff & amask) == '0);
  endfunction

  function automatic logic ptrs_empty(
    input logic [PTR_MAX_W-1:0] wp,
    input logic [PTR_MAX_W-1:0] rp
  );
    return wp == rp;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array: synchronous write, registered read with enable.
// Ports: clk, rst (clears rdata only), we/waddr/wdata, re/raddr/rdata.
module fifo_mem #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_d;
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with almost flags, sticky errors and occupancy.
// Ports: winc/wdata/wfull, rinc/rdata/rempty, status and clr_err.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int DSIZE      = 8,
  parameter int ASIZE      = 4,
  parameter int AFULL_THR  = 2**ASIZE-2,
  parameter int AEMPTY_THR = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  output logic             wfull,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
);

  localparam int DEPTH = 2**ASIZE;

  if (AFULL_THR < int'(AFULL_MIN) || AFULL_THR > DEPTH) begin : g_afull_bad
    $error("sync_fifo_flags: AFULL_THR out of range");
  end
  if (AEMPTY_THR < int'(AEMPTY_MIN) || AEMPTY_THR > DEPTH-1) begin : g_aempty_bad
    $error("sync_fifo_flags: AEMPTY_THR out of range");
  end

  localparam logic [ASIZE:0] AF_T = (ASIZE+1)'(AFULL_THR);
  localparam logic [ASIZE:0] AE_T = (ASIZE+1)'(AEMPTY_THR);

  typedef logic [ASIZE:0] ptr_t;

  ptr_t           wptr_q, wptr_d;
  ptr_t           rptr_q, rptr_d;
  logic [ASIZE:0] count_q, count_d;
  logic           wfull_q, wfull_d;
  logic           rempty_q, rempty_d;
  logic           af_q, af_d;
  logic           ae_q, ae_d;
  logic           ovf_q, ovf_d;
  logic           udf_q, udf_d;
  logic           wr_en, rd_en;

  // At full a same-cycle read frees the slot being written.
  assign wr_en = winc && (!wfull_q || rinc);
  assign rd_en = rinc && !rempty_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_en) wptr_d = wptr_q + 1'b1;
    if (rd_en) rptr_d = rptr_q + 1'b1;
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    wfull_d  = ptrs_full(PTR_MAX_W'(wptr_d), PTR_MAX_W'(rptr_d),
                         5'(ASIZE));
    rempty_d = ptrs_empty(PTR_MAX_W'(wptr_d), PTR_MAX_W'(rptr_d));
    af_d     = count_d >= AF_T;
    ae_d     = count_d <= AE_T;
    // Set beats clear when both land on the same edge.
    ovf_d = (winc && wfull_q && !rinc) || (ovf_q && !clr_err);
    udf_d = (rinc && rempty_q) || (udf_q && !clr_err);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      wfull_q  <= 1'b0;
      rempty_q <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      wfull_q  <= wfull_d;
      rempty_q <= rempty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifo_mem #(
    .DW(DSIZE),
    .AW(ASIZE)
  ) u_mem (
    .clk  (clk),
    .rst  (rst),
    .we   (wr_en && !rst),
    .waddr(wptr_q[ASIZE-1:0]),
    .wdata(wdata),
    .re   (rd_en && !rst),
    .raddr(rptr_q[ASIZE-1:0]),
    .rdata(rdata)
  );

  assign wfull        = wfull_q;
  assign rempty       = rempty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench for sync_fifo_flags: queue model plus directed vectors.
// Model compared on every falling edge; literal checks pin key points.
module tb_sync_fifo_flags;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       winc = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic       wfull;
  logic       rinc = 1'b0;
  logic [7:0] rdata;
  logic       rempty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;
  logic       clr_err = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  logic [7:0] mq[$];
  logic [7:0] m_rdata = 8'h00;
  bit         m_ovf = 1'b0;
  bit         m_udf = 1'b0;
  bit         m_wr_acc = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_flags dut (
    .clk(clk),
    .rst(rst),
    .winc(winc),
    .wdata(wdata),
    .wfull(wfull),
    .rinc(rinc),
    .rdata(rdata),
    .rempty(rempty),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .count(count),
    .overflow(overflow),
    .underflow(underflow),
    .clr_err(clr_err)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  // Reference behaviour: a queue of stored words plus sticky bits.
  always @(posedge clk) begin
    bit full, empty, do_rd, do_wr, ovf_set, udf_set;
    m_wr_acc = 1'b0;
    if (rst) begin
      mq.delete();
      m_rdata = 8'h00;
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      full    = (mq.size() == DEPTH);
      empty   = (mq.size() == 0);
      do_rd   = rinc && !empty;
      do_wr   = winc && (!full || rinc);
      ovf_set = winc && full && !rinc;
      udf_set = rinc && empty;
      if (do_rd) m_rdata = mq.pop_front();
      if (do_wr) mq.push_back(wdata);
      m_wr_acc = do_wr;
      m_ovf = ovf_set || (m_ovf && !clr_err);
      m_udf = udf_set || (m_udf && !clr_err);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("count", 32'(count), 32'(mq.size()));
      check("wfull", 32'(wfull), 32'(mq.size() == DEPTH));
      check("rempty", 32'(rempty), 32'(mq.size() == 0));
      check("almost_full", 32'(almost_full), 32'(mq.size() >= DEPTH-2));
      check("almost_empty", 32'(almost_empty), 32'(mq.size() <= 2));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("underflow", 32'(underflow), 32'(m_udf));
      check("rdata", 32'(rdata), 32'(m_rdata));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int wn;

  initial begin
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    check("lit_reset_count", 32'(count), 32'd0);
    check("lit_reset_rempty", 32'(rempty), 32'd1);
    check("lit_reset_aempty", 32'(almost_empty), 32'd1);

    // Fill with 0x01..0x10.
    for (int i = 1; i <= 16; i++) begin
      winc = 1'b1;
      wdata = 8'(i);
      step();
      if (i == 13) check("lit_af_at13", 32'(almost_full), 32'd0);
      if (i == 14) check("lit_af_at14", 32'(almost_full), 32'd1);
    end
    winc = 1'b0;
    check("lit_full_wfull", 32'(wfull), 32'd1);
    check("lit_full_count", 32'(count), 32'd16);
    check("lit_full_ovf", 32'(overflow), 32'd0);

    // Dropped write at full.
    winc = 1'b1;
    wdata = 8'hAA;
    step();
    winc = 1'b0;
    check("lit_ovf_set", 32'(overflow), 32'd1);
    check("lit_ovf_count", 32'(count), 32'd16);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("lit_ovf_clr", 32'(overflow), 32'd0);

    // Simultaneous read and write at full.
    winc = 1'b1;
    rinc = 1'b1;
    wdata = 8'hBB;
    step();
    winc = 1'b0;
    rinc = 1'b0;
    check("lit_rw_full_rdata", 32'(rdata), 32'h01);
    check("lit_rw_full_count", 32'(count), 32'd16);
    check("lit_rw_full_wfull", 32'(wfull), 32'd1);
    check("lit_rw_full_ovf", 32'(overflow), 32'd0);

    // Drain: 0x02..0x10 then 0xBB.
    rinc = 1'b1;
    for (int i = 0; i < 16; i++) step();
    rinc = 1'b0;
    check("lit_drain_rempty", 32'(rempty), 32'd1);
    check("lit_drain_last", 32'(rdata), 32'hBB);

    // Simultaneous read and write at empty: no fall-through.
    winc = 1'b1;
    rinc = 1'b1;
    wdata = 8'h55;
    step();
    winc = 1'b0;
    rinc = 1'b0;
    check("lit_rw_empty_udf", 32'(underflow), 32'd1);
    check("lit_rw_empty_count", 32'(count), 32'd1);
    rinc = 1'b1;
    step();
    rinc = 1'b0;
    check("lit_rw_empty_rdata", 32'(rdata), 32'h55);
    check("lit_rw_empty_rempty", 32'(rempty), 32'd1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;

    // Random traffic, 40 accepted writes, pointers wrap twice.
    wn = 0;
    for (int c = 0; c < 600 && wn < 40; c++) begin
      winc = 1'($urandom_range(0, 1));
      rinc = 1'($urandom_range(0, 1));
      wdata = 8'(8'h30 + wn);
      step();
      if (m_wr_acc) wn++;
    end
    winc = 1'b0;
    check("rand_writes_done", 32'(wn), 32'd40);
    rinc = 1'b1;
    for (int c = 0; c < 40 && mq.size() > 0; c++) step();
    rinc = 1'b0;
    step();
    check("rand_drained", 32'(rempty), 32'd1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;

    // Reset mid-stream with errors pending.
    rinc = 1'b1;
    step();
    rinc = 1'b0;
    check("lit_pre_rst_udf", 32'(underflow), 32'd1);
    for (int i = 0; i < 7; i++) begin
      winc = 1'b1;
      wdata = 8'(8'hC0 + i);
      step();
    end
    check("lit_pre_rst_count", 32'(count), 32'd7);
    rinc = 1'b1;
    step();
    check("lit_pre_rst_rdata", 32'(rdata), 32'hC0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    winc = 1'b0;
    rinc = 1'b0;
    check("lit_rst_count", 32'(count), 32'd0);
    check("lit_rst_rempty", 32'(rempty), 32'd1);
    check("lit_rst_udf", 32'(underflow), 32'd0);
    check("lit_rst_rdata", 32'(rdata), 32'd0);
    check("lit_rst_ae", 32'(almost_empty), 32'd1);
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
